// File: rtl/updown_trace_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | updown_trace_pkg: shared types and constants for the trace decoder   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package updown_trace_pkg;

  localparam int BYTE_W = 8;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    TRACK = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_fifo: small byte FIFO, power-of-two depth, head read-through   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module trace_fifo
  import updown_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  output logic              full,
  input  logic              pop,
  output logic              empty,
  output logic [BYTE_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign head      = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/updown_trace_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | updown_trace_decoder: recovers up/down steps from a counter bus and  |
// | streams them out as LSB-first packed bytes. Revision: 1.0            |
// +----------------------------------------------------------------------+
module updown_trace_decoder
  import updown_trace_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  value,
  input  logic              track,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              err,
  input  logic              err_clear,
  output logic              overflow
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [WIDTH-1:0]  r_prev;
  logic [6:0]        r_shift;
  logic [2:0]        r_count;
  logic              r_err;
  logic              r_overflow;

  logic [WIDTH-1:0]  w_delta;
  logic              w_step_up;
  logic              w_step_down;
  logic              w_step_ok;
  logic              w_dir;
  logic              w_decode;
  logic              w_push;
  logic [BYTE_W-1:0] w_push_data;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;

  assign w_delta     = value - r_prev;
  assign w_step_up   = (w_delta == ONE);
  assign w_step_down = (w_delta == '1);
  assign w_step_ok   = w_step_up | w_step_down;
  assign w_dir       = w_step_down ? DIR_DOWN : DIR_UP;
  assign w_decode    = (r_state == TRACK) && track;
  assign w_push      = w_decode && w_step_ok && (r_count == 3'd7);
  // Shift register fills from the top, so the oldest bit ends up at bit 0.
  assign w_push_data = {w_dir, r_shift};
  assign w_pop       = byte_valid & byte_ready;

  assign byte_valid  = ~w_empty;
  assign err         = r_err;
  assign overflow    = r_overflow;

  trace_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_data),
    .full      (w_full),
    .pop       (w_pop),
    .empty     (w_empty),
    .head      (byte_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_prev     <= '0;
      r_shift    <= '0;
      r_count    <= '0;
      r_err      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      // Clear first so a same-edge error assignment below takes priority.
      if (err_clear) r_err <= 1'b0;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;

      case (r_state)
        IDLE: begin
          if (track) r_state <= PRIME;
        end
        PRIME: begin
          r_prev  <= value;
          r_state <= track ? TRACK : IDLE;
        end
        TRACK: begin
          if (!track) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_count <= '0;
          end else begin
            r_prev <= value;
            if (w_step_ok) begin
              r_shift <= {w_dir, r_shift[6:1]};
              r_count <= r_count + 3'd1;
            end else begin
              r_err   <= 1'b1;
              r_shift <= '0;
              r_count <= '0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
